// File: rtl/decode_pkg.sv
// Shared decode constants: MIPS opcode/funct fields, ALU operation codes, operand/write-back selects.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_HLT    = 6'h3F;

  // REGIMM branches are distinguished by the rt field
  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;
  localparam logic [5:0] FN_MFHI   = 6'h10;
  localparam logic [5:0] FN_MTHI   = 6'h11;
  localparam logic [5:0] FN_MFLO   = 6'h12;
  localparam logic [5:0] FN_MTLO   = 6'h13;
  localparam logic [5:0] FN_MULT   = 6'h18;
  localparam logic [5:0] FN_MULTU  = 6'h19;
  localparam logic [5:0] FN_DIV    = 6'h1A;
  localparam logic [5:0] FN_DIVU   = 6'h1B;
  localparam logic [5:0] FN_ADD    = 6'h20;
  localparam logic [5:0] FN_SUB    = 6'h22;

  localparam logic [5:0] ALU_ADD   = 6'h20;
  localparam logic [5:0] ALU_ADDU  = 6'h21;
  localparam logic [5:0] ALU_SUBU  = 6'h23;
  localparam logic [5:0] ALU_AND   = 6'h24;
  localparam logic [5:0] ALU_OR    = 6'h25;
  localparam logic [5:0] ALU_XOR   = 6'h26;
  localparam logic [5:0] ALU_SLT   = 6'h2A;
  localparam logic [5:0] ALU_SLTU  = 6'h2B;
  localparam logic [5:0] ALU_LUI   = 6'h3F;

  typedef enum logic [1:0] {
    SRC_RD2   = 2'd0,
    SRC_SIGN  = 2'd1,
    SRC_ZERO  = 2'd2,
    SRC_UPPER = 2'd3
  } alu_src_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_HILO = 2'd2
  } wb_sel_e;

  localparam int BR_BEQ  = 0;
  localparam int BR_BNE  = 1;
  localparam int BR_BLEZ = 2;
  localparam int BR_BGTZ = 3;
  localparam int BR_BGEZ = 4;
  localparam int BR_BLTZ = 5;

  localparam int MD_MULT = 0;
  localparam int MD_DIV  = 1;
  localparam int MD_MFHI = 2;
  localparam int MD_MFLO = 3;
  localparam int MD_MTHI = 4;
  localparam int MD_MTLO = 5;

endpackage

// File: rtl/regfile.sv
// 32x32 register file, two combinational read ports, one write port; r0 is hardwired to zero.
// DECODE_BYPASS_EN forwards same-cycle write data to a matching read port.
module regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);

  logic [31:0] r_mem [32];
  logic        w_wr;

  assign w_wr = i_we && (i_wa != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[i_wa] <= i_wd;
    end
  end

`ifdef DECODE_BYPASS_EN
  assign o_rd1 = (w_wr && (i_wa == i_ra1)) ? i_wd : r_mem[i_ra1];
  assign o_rd2 = (w_wr && (i_wa == i_ra2)) ? i_wd : r_mem[i_ra2];
`else
  assign o_rd1 = r_mem[i_ra1];
  assign o_rd2 = r_mem[i_ra2];
`endif

endmodule

// File: rtl/decode.sv
// MIPS decode stage: IF/ID register, register file and combinational control decode (one-cycle latency).
// Optional same-cycle write-to-read forwarding when DECODE_BYPASS_EN is defined.
module decode
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] PC4_f,
  input  logic        wr_reg_en_wb,
  input  logic [4:0]  wr_reg_addr_wb,
  input  logic [31:0] res_wb,
  input  logic        link_wb,
  input  logic [31:0] PC4_wb,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] sign_imm_d,
  output logic [31:0] zero_imm_d,
  output logic [31:0] upper_imm_d,
  output logic [4:0]  shamt_d,
  output logic [4:0]  rs_d,
  output logic [4:0]  rt_d,
  output logic [4:0]  wr_reg_addr_d,
  output logic [31:0] PC4_d,
  output logic [5:0]  alu_control,
  output logic [1:0]  alu_src,
  output logic [1:0]  mem_to_reg,
  output logic        wr_reg_en_d,
  output logic        mem_wr,
  output logic        link_d,
  output logic        branch,
  output logic        sign_zero_ext,
  output logic        store_hb,
  output logic        overflow,
  output logic        hlt,
  output logic        NOP,
  output logic [5:0]  br_type,
  output logic [5:0]  md_op
);

  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [4:0]  w_rd;
  logic [31:0] w_wd;
  alu_src_e    w_alu_src;
  wb_sel_e     w_wb_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr <= '0;
      r_pc4   <= '0;
    end else begin
      r_instr <= instruction;
      r_pc4   <= PC4_f;
    end
  end

  assign w_wd = link_wb ? PC4_wb : res_wb;

  regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .i_ra1 (r_instr[25:21]),
    .i_ra2 (r_instr[20:16]),
    .i_we  (wr_reg_en_wb),
    .i_wa  (wr_reg_addr_wb),
    .i_wd  (w_wd),
    .o_rd1 (RD1),
    .o_rd2 (RD2)
  );

  assign w_op        = r_instr[31:26];
  assign w_fn        = r_instr[5:0];
  assign w_rd        = r_instr[15:11];
  assign rs_d        = r_instr[25:21];
  assign rt_d        = r_instr[20:16];
  assign shamt_d     = r_instr[10:6];
  assign sign_imm_d  = {{16{r_instr[15]}}, r_instr[15:0]};
  assign zero_imm_d  = {16'h0, r_instr[15:0]};
  assign upper_imm_d = {r_instr[15:0], 16'h0};
  assign PC4_d       = r_pc4;
  assign alu_src     = w_alu_src;
  assign mem_to_reg  = w_wb_sel;

  always_comb begin
    alu_control   = ALU_ADDU;
    w_alu_src     = SRC_RD2;
    w_wb_sel      = WB_ALU;
    wr_reg_addr_d = rt_d;
    wr_reg_en_d   = 1'b0;
    mem_wr        = 1'b0;
    link_d        = 1'b0;
    branch        = 1'b0;
    sign_zero_ext = 1'b1;
    store_hb      = 1'b0;
    overflow      = 1'b0;
    hlt           = 1'b0;
    NOP           = 1'b0;
    br_type       = '0;
    md_op         = '0;
    if (r_instr == 32'h0) begin
      NOP = 1'b1;
    end else begin
      case (w_op)
        OP_RTYPE: begin
          alu_control   = w_fn;
          wr_reg_addr_d = w_rd;
          wr_reg_en_d   = 1'b1;
          overflow      = (w_fn == FN_ADD) || (w_fn == FN_SUB);
          case (w_fn)
            FN_JR:             wr_reg_en_d = 1'b0;
            FN_JALR:           link_d = 1'b1;
            FN_MFHI:           begin w_wb_sel = WB_HILO; md_op[MD_MFHI] = 1'b1; end
            FN_MFLO:           begin w_wb_sel = WB_HILO; md_op[MD_MFLO] = 1'b1; end
            FN_MTHI:           begin wr_reg_en_d = 1'b0; md_op[MD_MTHI] = 1'b1; end
            FN_MTLO:           begin wr_reg_en_d = 1'b0; md_op[MD_MTLO] = 1'b1; end
            FN_MULT, FN_MULTU: begin wr_reg_en_d = 1'b0; md_op[MD_MULT] = 1'b1; end
            FN_DIV, FN_DIVU:   begin wr_reg_en_d = 1'b0; md_op[MD_DIV] = 1'b1; end
            default: ;
          endcase
        end
        OP_REGIMM: begin
          alu_control = ALU_SUBU;
          case (rt_d)
            RT_BLTZ:   begin branch = 1'b1; br_type[BR_BLTZ] = 1'b1; end
            RT_BGEZ:   begin branch = 1'b1; br_type[BR_BGEZ] = 1'b1; end
            RT_BLTZAL: begin
              branch = 1'b1; br_type[BR_BLTZ] = 1'b1;
              link_d = 1'b1; wr_reg_en_d = 1'b1; wr_reg_addr_d = 5'd31;
            end
            RT_BGEZAL: begin
              branch = 1'b1; br_type[BR_BGEZ] = 1'b1;
              link_d = 1'b1; wr_reg_en_d = 1'b1; wr_reg_addr_d = 5'd31;
            end
            default: NOP = 1'b1;
          endcase
        end
        OP_J: ;
        OP_JAL: begin link_d = 1'b1; wr_reg_en_d = 1'b1; wr_reg_addr_d = 5'd31; end
        OP_BEQ:  begin alu_control = ALU_SUBU; branch = 1'b1; br_type[BR_BEQ]  = 1'b1; end
        OP_BNE:  begin alu_control = ALU_SUBU; branch = 1'b1; br_type[BR_BNE]  = 1'b1; end
        OP_BLEZ: begin alu_control = ALU_SUBU; branch = 1'b1; br_type[BR_BLEZ] = 1'b1; end
        OP_BGTZ: begin alu_control = ALU_SUBU; branch = 1'b1; br_type[BR_BGTZ] = 1'b1; end
        OP_ADDI:  begin alu_control = ALU_ADD;  w_alu_src = SRC_SIGN;  wr_reg_en_d = 1'b1; overflow = 1'b1; end
        OP_ADDIU: begin alu_control = ALU_ADDU; w_alu_src = SRC_SIGN;  wr_reg_en_d = 1'b1; end
        OP_SLTI:  begin alu_control = ALU_SLT;  w_alu_src = SRC_SIGN;  wr_reg_en_d = 1'b1; end
        OP_SLTIU: begin alu_control = ALU_SLTU; w_alu_src = SRC_SIGN;  wr_reg_en_d = 1'b1; end
        OP_ANDI:  begin alu_control = ALU_AND;  w_alu_src = SRC_ZERO;  wr_reg_en_d = 1'b1; end
        OP_ORI:   begin alu_control = ALU_OR;   w_alu_src = SRC_ZERO;  wr_reg_en_d = 1'b1; end
        OP_XORI:  begin alu_control = ALU_XOR;  w_alu_src = SRC_ZERO;  wr_reg_en_d = 1'b1; end
        OP_LUI:   begin alu_control = ALU_LUI;  w_alu_src = SRC_UPPER; wr_reg_en_d = 1'b1; end
        OP_LB, OP_LW: begin
          w_alu_src = SRC_SIGN; wr_reg_en_d = 1'b1; w_wb_sel = WB_MEM;
        end
        OP_LBU: begin
          w_alu_src = SRC_SIGN; wr_reg_en_d = 1'b1; w_wb_sel = WB_MEM; sign_zero_ext = 1'b0;
        end
        OP_SB: begin w_alu_src = SRC_SIGN; mem_wr = 1'b1; store_hb = 1'b1; end
        OP_SW: begin w_alu_src = SRC_SIGN; mem_wr = 1'b1; end
        OP_HLT: hlt = 1'b1;
        default: NOP = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_decode.sv
// Directed self-checking bench for the decode stage; expectations are hand-decoded instruction fields.
module tb_decode;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = '0;
  logic [31:0] PC4_f = '0;
  logic        wr_reg_en_wb = 1'b0;
  logic [4:0]  wr_reg_addr_wb = '0;
  logic [31:0] res_wb = '0;
  logic        link_wb = 1'b0;
  logic [31:0] PC4_wb = '0;
  logic [31:0] RD1, RD2, sign_imm_d, zero_imm_d, upper_imm_d, PC4_d;
  logic [4:0]  shamt_d, rs_d, rt_d, wr_reg_addr_d;
  logic [5:0]  alu_control, br_type, md_op;
  logic [1:0]  alu_src, mem_to_reg;
  logic        wr_reg_en_d, mem_wr, link_d, branch, sign_zero_ext, store_hb, overflow, hlt, NOP;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  decode dut (
    .clk(clk), .reset(reset), .instruction(instruction), .PC4_f(PC4_f),
    .wr_reg_en_wb(wr_reg_en_wb), .wr_reg_addr_wb(wr_reg_addr_wb), .res_wb(res_wb),
    .link_wb(link_wb), .PC4_wb(PC4_wb),
    .RD1(RD1), .RD2(RD2), .sign_imm_d(sign_imm_d), .zero_imm_d(zero_imm_d),
    .upper_imm_d(upper_imm_d), .shamt_d(shamt_d), .rs_d(rs_d), .rt_d(rt_d),
    .wr_reg_addr_d(wr_reg_addr_d), .PC4_d(PC4_d), .alu_control(alu_control),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .wr_reg_en_d(wr_reg_en_d),
    .mem_wr(mem_wr), .link_d(link_d), .branch(branch), .sign_zero_ext(sign_zero_ext),
    .store_hb(store_hb), .overflow(overflow), .hlt(hlt), .NOP(NOP),
    .br_type(br_type), .md_op(md_op)
  );

  // Register an instruction through IF/ID, then settle just after the edge.
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc4);
    @(negedge clk);
    instruction = ins;
    PC4_f       = pc4;
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data,
                          input logic lnk, input logic [31:0] pc4);
    @(negedge clk);
    wr_reg_en_wb = 1'b1; wr_reg_addr_wb = addr; res_wb = data; link_wb = lnk; PC4_wb = pc4;
    @(posedge clk);
    #1;
    wr_reg_en_wb = 1'b0; link_wb = 1'b0;
  endtask

  task automatic test_reset;
    instruction = 32'h00221820; PC4_f = 32'h1234;
    repeat (2) @(negedge clk);
    checks++; if (RD1 !== 32'h0) begin fails++; $display("FAIL reset_rd1 got %h exp 0", RD1); end
    checks++; if (RD2 !== 32'h0) begin fails++; $display("FAIL reset_rd2 got %h exp 0", RD2); end
    checks++; if (PC4_d !== 32'h0) begin fails++; $display("FAIL reset_pc4 got %h exp 0", PC4_d); end
    checks++; if (NOP !== 1'b1) begin fails++; $display("FAIL reset_nop got %b exp 1", NOP); end
    checks++; if (wr_reg_en_d !== 1'b0) begin fails++; $display("FAIL reset_wren got %b exp 0", wr_reg_en_d); end
    reset = 1'b0; instruction = '0; PC4_f = '0;
  endtask

  task automatic test_add;
    wb_write(5'd1, 32'h0000000F, 1'b0, 32'h0);
    wb_write(5'd2, 32'h00000003, 1'b0, 32'h0);
    issue(32'h00221820, 32'h00000104);
    checks++; if (RD1 !== 32'hF) begin fails++; $display("FAIL add_rd1 got %h exp f", RD1); end
    checks++; if (RD2 !== 32'h3) begin fails++; $display("FAIL add_rd2 got %h exp 3", RD2); end
    checks++; if (alu_control !== 6'h20) begin fails++; $display("FAIL add_aluc got %h exp 20", alu_control); end
    checks++; if (wr_reg_addr_d !== 5'd3) begin fails++; $display("FAIL add_wra got %0d exp 3", wr_reg_addr_d); end
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL add_ovf got %b exp 1", overflow); end
    checks++; if ({wr_reg_en_d, alu_src, NOP} !== 4'b1000) begin fails++; $display("FAIL add_ctl got %b exp 1000", {wr_reg_en_d, alu_src, NOP}); end
    checks++; if (PC4_d !== 32'h104) begin fails++; $display("FAIL add_pc4 got %h exp 104", PC4_d); end
  endtask

  task automatic test_imm;
    issue(32'h3C01ABCD, 32'h0);
    checks++; if (upper_imm_d !== 32'hABCD0000) begin fails++; $display("FAIL lui_upper got %h exp abcd0000", upper_imm_d); end
    checks++; if (alu_src !== 2'd3) begin fails++; $display("FAIL lui_src got %0d exp 3", alu_src); end
    checks++; if ({alu_control, wr_reg_addr_d} !== {6'h3F, 5'd1}) begin fails++; $display("FAIL lui_ctl got %h/%0d exp 3f/1", alu_control, wr_reg_addr_d); end
    issue(32'h2001FFFF, 32'h0);
    checks++; if (sign_imm_d !== 32'hFFFFFFFF) begin fails++; $display("FAIL addi_sign got %h exp ffffffff", sign_imm_d); end
    checks++; if (zero_imm_d !== 32'h0000FFFF) begin fails++; $display("FAIL addi_zero got %h exp 0000ffff", zero_imm_d); end
    checks++; if ({overflow, alu_src, alu_control} !== {1'b1, 2'd1, 6'h20}) begin fails++; $display("FAIL addi_ctl got %b/%0d/%h exp 1/1/20", overflow, alu_src, alu_control); end
    issue(32'h3022FFFF, 32'h0);
    checks++; if ({overflow, alu_src, alu_control} !== {1'b0, 2'd2, 6'h24}) begin fails++; $display("FAIL andi_ctl got %b/%0d/%h exp 0/2/24", overflow, alu_src, alu_control); end
  endtask

  task automatic test_r0;
    wb_write(5'd0, 32'h5, 1'b0, 32'h0);
    issue(32'h00000020, 32'h0);
    checks++; if ({RD1, RD2} !== 64'h0) begin fails++; $display("FAIL r0_read got %h/%h exp 0/0", RD1, RD2); end
  endtask

  task automatic test_link;
    wb_write(5'd31, 32'h0000DEAD, 1'b1, 32'h00000200);
    issue(32'h03E00008, 32'h0);
    checks++; if (RD1 !== 32'h200) begin fails++; $display("FAIL link_data got %h exp 200", RD1); end
    checks++; if ({wr_reg_en_d, alu_control} !== {1'b0, 6'h08}) begin fails++; $display("FAIL jr_ctl got %b/%h exp 0/08", wr_reg_en_d, alu_control); end
  endtask

  task automatic test_bypass;
    logic [31:0] exp_rd1;
`ifdef DECODE_BYPASS_EN
    exp_rd1 = 32'h12;
`else
    exp_rd1 = 32'h7;
`endif
    wb_write(5'd5, 32'h7, 1'b0, 32'h0);
    issue(32'h00A00020, 32'h0);
    wr_reg_en_wb = 1'b1; wr_reg_addr_wb = 5'd5; res_wb = 32'h12;
    #1;
    checks++; if (RD1 !== exp_rd1) begin fails++; $display("FAIL bypass_same got %h exp %h", RD1, exp_rd1); end
    @(posedge clk); #1;
    wr_reg_en_wb = 1'b0;
    checks++; if (RD1 !== 32'h12) begin fails++; $display("FAIL bypass_after got %h exp 12", RD1); end
  endtask

  task automatic test_mem;
    issue(32'h8C220004, 32'h0);
    checks++; if ({mem_to_reg, sign_zero_ext, wr_reg_en_d, mem_wr, alu_src, alu_control} !== {2'd1, 1'b1, 1'b1, 1'b0, 2'd1, 6'h21})
      begin fails++; $display("FAIL lw_ctl got %b/%b/%b/%b/%0d/%h", mem_to_reg, sign_zero_ext, wr_reg_en_d, mem_wr, alu_src, alu_control); end
    issue(32'h90220004, 32'h0);
    checks++; if ({mem_to_reg, sign_zero_ext} !== {2'd1, 1'b0}) begin fails++; $display("FAIL lbu_ctl got %0d/%b exp 1/0", mem_to_reg, sign_zero_ext); end
    issue(32'hA0220004, 32'h0);
    checks++; if ({mem_wr, store_hb, wr_reg_en_d} !== 3'b110) begin fails++; $display("FAIL sb_ctl got %b exp 110", {mem_wr, store_hb, wr_reg_en_d}); end
    issue(32'hAC220004, 32'h0);
    checks++; if ({mem_wr, store_hb, wr_reg_en_d} !== 3'b100) begin fails++; $display("FAIL sw_ctl got %b exp 100", {mem_wr, store_hb, wr_reg_en_d}); end
  endtask

  task automatic test_branch_md;
    issue(32'h10220003, 32'h0);
    checks++; if ({branch, br_type, alu_control, wr_reg_en_d} !== {1'b1, 6'b000001, 6'h23, 1'b0})
      begin fails++; $display("FAIL beq_ctl got %b/%b/%h/%b", branch, br_type, alu_control, wr_reg_en_d); end
    issue(32'h04310003, 32'h0);
    checks++; if ({branch, br_type, link_d, wr_reg_en_d, wr_reg_addr_d} !== {1'b1, 6'b010000, 1'b1, 1'b1, 5'd31})
      begin fails++; $display("FAIL bgezal_ctl got %b/%b/%b/%b/%0d", branch, br_type, link_d, wr_reg_en_d, wr_reg_addr_d); end
    issue(32'h00220018, 32'h0);
    checks++; if ({md_op, wr_reg_en_d} !== {6'b000001, 1'b0}) begin fails++; $display("FAIL mult_ctl got %b/%b", md_op, wr_reg_en_d); end
    issue(32'h00001810, 32'h0);
    checks++; if ({md_op, mem_to_reg, wr_reg_en_d, wr_reg_addr_d} !== {6'b000100, 2'd2, 1'b1, 5'd3})
      begin fails++; $display("FAIL mfhi_ctl got %b/%0d/%b/%0d", md_op, mem_to_reg, wr_reg_en_d, wr_reg_addr_d); end
  endtask

  task automatic test_nop_hlt;
    issue(32'hFC000000, 32'h0);
    checks++; if ({hlt, NOP, wr_reg_en_d} !== 3'b100) begin fails++; $display("FAIL hlt_ctl got %b exp 100", {hlt, NOP, wr_reg_en_d}); end
    issue(32'hF0000000, 32'h0);
    checks++; if ({NOP, hlt, wr_reg_en_d, mem_wr, branch, link_d, md_op} !== {1'b1, 11'b0})
      begin fails++; $display("FAIL unknown_ctl got %b", {NOP, hlt, wr_reg_en_d, mem_wr, branch, link_d, md_op}); end
    issue(32'h00000000, 32'h0);
    checks++; if ({NOP, wr_reg_en_d, mem_wr, branch, link_d, md_op} !== {1'b1, 10'b0})
      begin fails++; $display("FAIL zero_nop got %b", {NOP, wr_reg_en_d, mem_wr, branch, link_d, md_op}); end
  endtask

  task automatic test_reset_clears_regs;
    issue(32'h00221820, 32'h0000ABCD);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if ({PC4_d, NOP} !== {32'h0, 1'b1}) begin fails++; $display("FAIL rst2_state got %h/%b exp 0/1", PC4_d, NOP); end
    @(negedge clk);
    reset = 1'b0;
    issue(32'h00221820, 32'h0);
    checks++; if ({RD1, RD2} !== 64'h0) begin fails++; $display("FAIL rst2_regs got %h/%h exp 0/0", RD1, RD2); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_imm;
    test_r0;
    test_link;
    test_bypass;
    test_mem;
    test_branch_md;
    test_nop_hlt;
    test_reset_clears_regs;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 instruction  input  32  fetched MIPS instruction.
REQ-004 PC4_f  input  32  fetch-stage PC+4.
REQ-005 wr_reg_en_wb  input  1  write-back register write enable.
REQ-006 wr_reg_addr_wb  input  5  write-back destination register.
REQ-007 res_wb  input  32  write-back result data.
REQ-008 link_wb, PC4_wb  input  1/32  link write selector and its PC+4 data.
REQ-009 RD1, RD2  output  32  register file read data for rs and rt.
REQ-010 sign_imm_d, zero_imm_d, upper_imm_d  output  32  sign-extended, zero-extended and {imm,16'h0} immediates.
REQ-011 shamt_d, rs_d, rt_d, wr_reg_addr_d  output  5  shift amount, source fields and selected destination.
REQ-012 PC4_d  output  32  registered PC+4.
REQ-013 alu_control  output  6  ALU operation code.
REQ-014 alu_src, mem_to_reg  output  2  ALU B select (0 RD2, 1 sign, 2 zero, 3 upper) and write-back select (0 ALU, 1 memory, 2 HI/LO).
REQ-015 wr_reg_en_d, mem_wr, link_d, branch, sign_zero_ext, store_hb, overflow, hlt, NOP  output  1  control flags.
REQ-016 br_type  output  6  one-hot {bltz,bgez,bgtz,blez,bne,beq}.
REQ-017 md_op  output  6  one-hot {mtlo,mthi,mflo,mfhi,div,mult}.

Function
REQ-018 The IF/ID register SHALL capture instruction and PC4_f on every rising clk; all decoding SHALL be combinational from the registered instruction (one-cycle latency).
REQ-019 The register file SHALL hold 32x32 entries, register 0 SHALL read 0 and never be written.
REQ-020 A write SHALL occur on rising clk when wr_reg_en_wb=1 and wr_reg_addr_wb!=0; data SHALL be PC4_wb when link_wb=1, else res_wb.
REQ-021 R-type: alu_control=funct, wr_reg_addr_d=rd, alu_src=0; I-type: wr_reg_addr_d=rt; jal/bltzal/bgezal: wr_reg_addr_d=31, link_d=1.
REQ-022 I-type alu_control: addi 0x20, addiu/lw/lb/lbu/sw/sb 0x21, andi 0x24, ori 0x25, xori 0x26, slti 0x2A, sltiu 0x2B, lui 0x3F, branches 0x23.
REQ-023 alu_src SHALL be 1 for addi/addiu/slti/sltiu/loads/stores, 2 for andi/ori/xori, 3 for lui.
REQ-024 Loads SHALL set mem_to_reg=1; lbu SHALL set sign_zero_ext=0, lb/lw 1; sb SHALL set store_hb=1; stores SHALL set mem_wr=1, wr_reg_en_d=0.
REQ-025 branch SHALL be 1 with exactly one br_type bit for beq/bne/blez/bgtz/bgez/bltz; mfhi/mflo SHALL set mem_to_reg=2, wr_reg_en_d=1.
REQ-026 overflow SHALL be 1 only for add, addi, sub.
REQ-027 NOP SHALL be 1 when the registered instruction is 0, forcing all enables (wr_reg_en_d, mem_wr, branch, md_op, link_d) to 0.
REQ-028 hlt SHALL be 1 for opcode 6'h3F; unknown opcodes SHALL decode as NOP with all enables 0.

Reset
REQ-029 Reset SHALL clear IF/ID register (instruction=0, PC4_d=0) and all 32 registers to 0; outputs then reflect NOP decode with RD1=RD2=0.

Configuration
REQ-030 With DECODE_BYPASS_EN defined, a read of the register being written that cycle SHALL return the new write data; without it, the old value is returned.

Structure
REQ-031 Package decode_pkg SHALL hold opcode/funct constants, alu_control codes and alu_src/mem_to_reg encodings.
REQ-032 The register file SHALL be a sub-module named regfile.

Verification
REQ-033 Reset asserted -> RD1=RD2=0, PC4_d=0, NOP=1.
REQ-034 Write r1=0x0000000F, then instruction 0x00221820 (add r3,r1,r2) -> RD1=0xF, alu_control=0x20, wr_reg_addr_d=3, overflow=1.
REQ-035 instruction 0x3C01ABCD (lui) -> upper_imm_d=0xABCD0000, alu_src=3.
REQ-036 instruction 0x2001FFFF (addi) -> sign_imm_d=0xFFFFFFFF, zero_imm_d=0x0000FFFF.
REQ-037 wr_reg_en_wb=1, addr 0, res_wb=0x5 -> r0 still reads 0.
REQ-038 Same-cycle write r5=0x12 and read r5 -> RD1=0x12 with DECODE_BYPASS_EN, previous value without it.
